// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path (and the future
// transmitter).
//   - rx_state_t      : receiver FSM state encoding (3 bits)
//   - OVERSAMPLE      : sample ticks per bit
//   - VOTE_A/B/C      : sample indices used for the 2-of-3 majority vote;
//                       the bit decision is taken at VOTE_C
//   - LAST_SAMPLE     : final sample index of a bit period
//   - calc_tick_div() : clocks per sample tick, rounded to nearest
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] VOTE_A      = 4'd7;
    localparam logic [3:0] VOTE_B      = 4'd8;
    localparam logic [3:0] VOTE_C      = 4'd9;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    // round(clk_freq / (baud * OVERSAMPLE)), never below 1
    function automatic int calc_tick_div(input int clk_freq, input int baud);
        int div;
        div = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: sample-tick divider.
//   clk   : system clock
//   reset : synchronous, active-low
//   clear : holds the counter at 0 (no tick) while high
//   tick  : one-clock pulse every TICK_DIV clocks, at counter wrap
module uart_baud_tick #(
    parameter int TICK_DIV = 326
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int             CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Suppressed during clear so a restarted divider never fires early.
    assign tick = !clear && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with 16x oversampling and 2-of-3
// majority vote per bit.
//   clk          : system clock, rising edge
//   reset        : synchronous, active-low
//   uart_rxd     : raw serial line, idle high, asynchronous to clk
//   rx_ack       : one-cycle pulse, current byte consumed
//   rx_data      : last received byte
//   rx_valid     : rx_data holds an unread byte
//   rx_overrun   : sticky, a byte was dropped while rx_valid was set
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_busy      : FSM is not in IDLE
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD);

    logic [1:0] sync_reg;
    logic       rxd_s;
    rx_state_t  state_reg;
    logic [3:0] sample_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_data_reg;
    logic [1:0] vote_reg;
    logic       deliver_reg;
    logic       frame_err_reg;
    logic [7:0] data_reg;
    logic       valid_reg;
    logic       overrun_reg;

    logic       tick;
    logic [3:0] sample_next;
    logic       vote_maj;
    logic       at_vote;
    logic       at_end;

    // Two-flop synchronizer; nothing downstream looks at uart_rxd directly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_rxd};
        end
    end
    assign rxd_s = sync_reg[1];

    // Divider is held in IDLE, so the first tick lands TICK_DIV clocks after
    // start detection and bit periods align to the falling edge.
    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_reg == IDLE),
        .tick  (tick)
    );

    // A sample's index is the count value it advances to, so the 16th tick of
    // a bit is sample 15 and the next bit opens with sample 0.
    assign sample_next = sample_cnt_reg + 4'd1;
    assign at_vote     = tick && (sample_next == VOTE_C);
    assign at_end      = tick && (sample_next == LAST_SAMPLE);
    // Samples VOTE_A and VOTE_B are stored; VOTE_C is the live input.
    assign vote_maj    = (vote_reg[0] & vote_reg[1]) |
                         (vote_reg[0] & rxd_s) |
                         (vote_reg[1] & rxd_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_data_reg <= '0;
            vote_reg       <= '0;
            deliver_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            deliver_reg   <= 1'b0;
            frame_err_reg <= 1'b0;

            if (tick) begin
                sample_cnt_reg <= sample_next;
                if (sample_next == VOTE_A) vote_reg[0] <= rxd_s;
                if (sample_next == VOTE_B) vote_reg[1] <= rxd_s;
            end

            case (state_reg)
                IDLE: begin
                    sample_cnt_reg <= '0;
                    bit_cnt_reg    <= '0;
                    if (!rxd_s) state_reg <= START;
                end
                START: begin
                    if (at_vote && vote_maj) begin
                        state_reg <= IDLE;      // glitch, not a start bit
                    end else if (at_end) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                    end
                end
                DATA: begin
                    if (at_vote) shift_data_reg <= {vote_maj, shift_data_reg[7:1]};
                    if (at_end) begin
                        if (bit_cnt_reg == 3'd7) state_reg <= STOP;
                        else                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end
                end
                STOP: begin
                    // Leave at the vote rather than sample 15 so a start bit
                    // immediately following the stop bit is not missed.
                    if (at_vote) begin
                        if (vote_maj) begin
                            deliver_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Output holding register. shift_data_reg only changes in DATA, so it is
    // still the delivered byte in the cycle after the stop vote.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (deliver_reg) begin
            if (!valid_reg || rx_ack) begin
                data_reg    <= shift_data_reg;
                valid_reg   <= 1'b1;
                overrun_reg <= 1'b0;
            end else begin
                overrun_reg <= 1'b1;            // unread byte kept, new one lost
            end
        end else if (rx_ack && valid_reg) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_overrun   = overrun_reg;
    assign rx_frame_err = frame_err_reg;
    assign rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames onto uart_rxd and checks the receiver's
// output register against an abstract model of the rx_data/rx_valid/
// rx_overrun registers. The clock/baud ratio is scaled down (4 clocks per
// sample tick) to keep runs short; the frame timing rules are unchanged.
module tb_uart_receiver;

    localparam int BAUD     = 9600;
    localparam int DIV      = 4;
    localparam int CLK_FREQ = BAUD * 16 * DIV;
    localparam int BIT_CLKS = 16 * DIV;
    // Start edge to rx_valid: 9 bits + 9 sample ticks, plus a few clocks.
    localparam int LATENCY  = (9 * 16 + 9) * DIV + 3;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
        logic       valid;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned frame_t0 = 0;
    int unsigned last_evt_cyc = 0;
    logic        mon_en = 1'b0;
    logic [9:0]  prev_tuple;
    logic        ferr_prev;

    exp_t        exp_q[$];
    logic [7:0]  m_data = 8'h00;
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic expect_tuple(input logic [7:0] d, input logic v, input logic o);
        if ({d, v, o} != {m_data, m_valid, m_ovr}) exp_q.push_back('{1'b0, d, v, o});
        m_data  = d;
        m_valid = v;
        m_ovr   = o;
    endtask

    // A good frame arriving with no simultaneous ack.
    task automatic model_frame(input logic [7:0] b);
        if (!m_valid) expect_tuple(b, 1'b1, 1'b0);
        else          expect_tuple(m_data, 1'b1, 1'b1);
    endtask

    // ---------------- line driver ----------------
    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (BIT_CLKS) @(posedge clk);
        #3;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        frame_t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic do_ack();
        if (m_valid) expect_tuple(m_data, 1'b0, 1'b0);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon_event(input exp_t cur);
        exp_t e;
        total++;
        last_evt_cyc = cyc;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got ferr=%0b data=%02h valid=%0b ovr=%0b want none",
                     cur.ferr, cur.data, cur.valid, cur.ovr);
        end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
                bad++;
                $display("FAIL out_event: got ferr=%0b data=%02h valid=%0b ovr=%0b want ferr=%0b data=%02h valid=%0b ovr=%0b",
                         cur.ferr, cur.data, cur.valid, cur.ovr, e.ferr, e.data, e.valid, e.ovr);
            end else begin
                $display("txn cyc=%0d ferr=%0b data=%02h valid=%0b ovr=%0b ok",
                         cyc, cur.ferr, cur.data, cur.valid, cur.ovr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_frame_err || ({rx_data, rx_valid, rx_overrun} != prev_tuple))
                mon_event({rx_frame_err, rx_data, rx_valid, rx_overrun});
            if (rx_frame_err) check("ferr_single_cycle", {31'd0, ferr_prev}, 32'd0);
        end
        prev_tuple <= {rx_data, rx_valid, rx_overrun};
        ferr_prev  <= rx_frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [7:0] b;
        int timeout;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        mon_en = 1'b1;
        reset  = 1'b1;
        repeat (4) @(posedge clk);
        #3;

        // 1: single frame, latency
        send_bit(1'b1);
        model_frame(8'hFA);
        send_frame(8'hFA, 1'b1);
        lat = int'(last_evt_cyc - frame_t0);
        total++;
        if (lat < LATENCY - 4 || lat > LATENCY + 4) begin
            bad++;
            $display("FAIL latency: got %0d clocks want %0d +/-4", lat, LATENCY);
        end
        check("t1_data", {24'd0, rx_data}, 32'hFA);
        check("t1_overrun", {31'd0, rx_overrun}, 32'd0);

        // 2: ack, then a frame one bit-time later
        do_ack();
        check("t2_valid_after_ack", {31'd0, rx_valid}, 32'd0);
        send_bit(1'b1);
        model_frame(8'h32);
        send_frame(8'h32, 1'b1);
        check("t2_data", {24'd0, rx_data}, 32'h32);

        // 3: back-to-back frames without ack -> overrun
        do_ack();
        model_frame(8'h55);
        send_frame(8'h55, 1'b1);
        model_frame(8'hA3);
        send_frame(8'hA3, 1'b1);
        check("t3_data_kept", {24'd0, rx_data}, 32'h55);
        check("t3_overrun", {31'd0, rx_overrun}, 32'd1);
        do_ack();
        check("t3_ack_clr_ovr", {31'd0, rx_overrun}, 32'd0);

        // 4: ack on the exact delivery cycle of a new byte
        model_frame(8'h11);
        send_frame(8'h11, 1'b1);
        send_bit(1'b1);
        expect_tuple(8'h3C, 1'b1, 1'b0);
        fork
            send_frame(8'h3C, 1'b1);
            begin
                // Delivery happens in the first cycle rx_busy reads low.
                repeat (2 * BIT_CLKS) @(negedge clk);
                timeout = 10 * BIT_CLKS;
                while (rx_busy && timeout > 0) begin
                    @(negedge clk);
                    timeout--;
                end
                check("t4_busy_fall_seen", {31'd0, rx_busy}, 32'd0);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        check("t4_data", {24'd0, rx_data}, 32'h3C);
        check("t4_valid", {31'd0, rx_valid}, 32'd1);
        check("t4_overrun", {31'd0, rx_overrun}, 32'd0);
        do_ack();

        // 5a: short low glitch -> false start
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_glitch_busy", {31'd0, rx_busy}, 32'd1);
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("t5_glitch_idle", {31'd0, rx_busy}, 32'd0);

        // 5b: stop bit low -> frame error, held until the line goes high
        exp_q.push_back('{1'b1, m_data, m_valid, m_ovr});
        send_frame(8'h96, 1'b0);
        repeat (3) send_bit(1'b0);
        check("t5_break_busy", {31'd0, rx_busy}, 32'd1);
        check("t5_break_valid", {31'd0, rx_valid}, 32'd0);
        send_bit(1'b1);
        check("t5_break_exit", {31'd0, rx_busy}, 32'd0);
        model_frame(8'h5A);
        send_frame(8'h5A, 1'b1);
        check("t5_after_break", {24'd0, rx_data}, 32'h5A);

        // 6: reset in the middle of the data bits
        send_bit(1'b1);
        b = 8'h7E;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        @(negedge clk);
        expect_tuple(8'h00, 1'b0, 1'b0);
        reset    = 1'b0;
        uart_rxd = 1'b1;
        @(posedge clk);
        #1;
        check("t6_data", {24'd0, rx_data}, 32'h00);
        check("t6_valid", {31'd0, rx_valid}, 32'd0);
        check("t6_overrun", {31'd0, rx_overrun}, 32'd0);
        check("t6_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("t6_busy", {31'd0, rx_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        send_bit(1'b1);
        model_frame(8'h81);
        send_frame(8'h81, 1'b1);
        check("t6_data_after", {24'd0, rx_data}, 32'h81);

        // Randomized frames, gaps and acks
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) send_bit(1'b1);
            b = 8'($urandom);
            model_frame(b);
            send_frame(b, 1'b1);
        end
        do_ack();

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
